data_memory_arbiter: RTL



---
 rtl/dmarb_pkg.sv | 23 ++
 rtl/dmarb_grant.sv | 34 +++
 rtl/data_memory_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dmarb_pkg.sv
// Shared types for the data memory arbiter: FSM state encoding and the
// per-cycle memory owner.
package dmarb_pkg;

  // State records who owned the memory port in the previous cycle.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CORE      = 2'd1,
    ST_LDR       = 2'd2,
    ST_LDR_BURST = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_LDR  = 2'd2
  } owner_t;

  function automatic logic is_ldr_state(input state_t s);
    return (s == ST_LDR) || (s == ST_LDR_BURST);
  endfunction

endpackage

// File: rtl/dmarb_grant.sv
// Combinational grant decision: locked loader burst, starvation relief,
// then core priority, then loader.
import dmarb_pkg::*;

module dmarb_grant (
  input  logic   en,
  input  state_t state,
  input  logic   core_req,
  input  logic   ldr_req,
  input  logic   ldr_lock,
  input  logic   burst_room,
  input  logic   starve_hit,
  output owner_t owner,
  output logic   lock_hit
);

  // NOTE: every output gets a default before any branch so no path can infer a latch.
  always_comb begin
    owner    = OWN_NONE;
    lock_hit = en && is_ldr_state(state) && ldr_req && ldr_lock && burst_room;
    if (!en) begin
      owner = OWN_NONE;
    end else if (lock_hit) begin
      owner = OWN_LDR;
    end else if (starve_hit && ldr_req) begin
      owner = OWN_LDR;
    end else if (core_req) begin
      owner = OWN_CORE;
    end else if (ldr_req) begin
      owner = OWN_LDR;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-requester data memory arbiter (core memory stage vs. loader) with
// locked loader bursts; starvation guard enabled by DMARB_STARVE_GUARD_EN.
import dmarb_pkg::*;

module data_memory_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic              ldr_lock,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int BW = $clog2(BURST_MAX + 1);

  if (STARVE_LIMIT < 1 || BURST_MAX < 1) begin : g_bad_param
    $error("data_memory_arbiter: STARVE_LIMIT and BURST_MAX must be >= 1");
  end

  state_t          state, state_d;
  owner_t          owner;
  logic            lock_hit;
  logic            core_gnt;
  logic            burst_room;
  logic            starve_hit;
  logic [BW-1:0]   burst_cnt;

  assign burst_room = burst_cnt < BW'(BURST_MAX);

  dmarb_grant u_grant (
    .en         (rst),
    .state      (state),
    .core_req   (core_req),
    .ldr_req    (ldr_req),
    .ldr_lock   (ldr_lock),
    .burst_room (burst_room),
    .starve_hit (starve_hit),
    .owner      (owner),
    .lock_hit   (lock_hit)
  );

  assign core_gnt   = (owner == OWN_CORE);
  assign ldr_gnt    = (owner == OWN_LDR);
  assign core_stall = core_req && !core_gnt;

  // With no grant the port idles on the core's address/data with writes off.
  assign mem_we   = ldr_gnt ? ldr_we    : (core_gnt && core_we);
  assign mem_addr = ldr_gnt ? ldr_addr  : core_addr;
  assign mem_wd   = ldr_gnt ? ldr_wdata : core_wdata;

  always_comb begin
    state_d = ST_IDLE;
    case (owner)
      OWN_CORE: state_d = ST_CORE;
      OWN_LDR:  state_d = lock_hit ? ST_LDR_BURST : ST_LDR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end else begin
      state <= state_d;
      // Any loader grant taken with lock held counts toward the burst,
      // including the one that opens it; saturates at BURST_MAX.
      if (ldr_gnt && ldr_lock) begin
        if (burst_room) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= '0;
      end
    end
  end

`ifdef DMARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!ldr_req || ldr_gnt) begin
      starve_cnt <= '0;
    end else if (core_gnt && !starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // NOTE: rdata registers are reset because their reset value is architecturally visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      ldr_rvalid  <= 1'b0;
      ldr_rdata   <= '0;
    end else begin
      core_rvalid <= core_gnt && !core_we;
      ldr_rvalid  <= ldr_gnt && !ldr_we;
      if (core_gnt && !core_we) core_rdata <= mem_rd;
      if (ldr_gnt && !ldr_we)   ldr_rdata  <= mem_rd;
    end
  end

endmodule
